mc_ctrl: RTL

Multi-cycle control FSM for the miniLA datapath. It sequences instruction fetch, decode, execute, memory access and writeback, and drives the ALU B-operand select (`alu_bsel`), the PC, register-file and data-memory strobes. It sits between the instruction-class decoder and the datapath muxes, so that one shared ALU serves address generation, arithmetic and branch compare in different cycles.

---
 rtl/mc_ctrl_pkg.sv | 51 +++++
 rtl/mc_perf_cnt.sv | 27 ++
 rtl/mc_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the miniLA multi-cycle control FSM.
// Holds the FSM state codes, decoder instruction classes, ALU B-port selects,
// next-PC selects and writeback-data selects. It also holds a helper that maps
// an instruction class to its ALU B-operand select.
package mc_ctrl_pkg;

  // FSM state encodings. Codes 6 and 7 are unused and recover to S_IF.
  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  // Instruction classes from the decoder. Codes 6 and 7 are illegal.
  localparam logic [2:0] CLS_ALU_R  = 3'd0;
  localparam logic [2:0] CLS_ALU_I  = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JUMP   = 3'd5;

  // ALU B-port select.
  localparam logic [1:0] ALUB_RS2  = 2'b00;
  localparam logic [1:0] ALUB_IMM1 = 2'b01;
  localparam logic [1:0] ALUB_IMM2 = 2'b10;

  // Next-PC select.
  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;

  // Register-file write-data select.
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  // Loads and stores use the ALU for address generation (IMM2).
  // ALU_I uses IMM1. Everything else, including illegal classes, compares
  // or operates on RS2.
  function automatic logic [1:0] bsel_of(input logic [2:0] cls);
    logic [1:0] sel;
    case (cls)
      CLS_ALU_I:           sel = ALUB_IMM1;
      CLS_LOAD, CLS_STORE: sel = ALUB_IMM2;
      default:             sel = ALUB_RS2;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// mc_perf_cnt: cycle and retired-instruction counters for mc_ctrl.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   cnt_en      - count this cycle (high whenever the FSM is not halted)
//   inst_inc    - one pulse per retired instruction (the PC write strobe)
//   cyc_cnt     - 32-bit free-running cycle count; wraps to 0
//   inst_cnt    - 32-bit instruction count; wraps to 0
module mc_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnt_en,
  input  logic        inst_inc,
  output logic [31:0] cyc_cnt,
  output logic [31:0] inst_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt  <= 32'd0;
      inst_cnt <= 32'd0;
    end else begin
      if (cnt_en)   cyc_cnt  <= cyc_cnt + 32'd1;
      if (inst_inc) inst_cnt <= inst_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the miniLA datapath.
// Sequences IF -> ID -> EX -> (MEM) -> (WB), and parks in HALT on request at an
// instruction boundary.
// Optional feature: define MC_PERF_CNT_EN to add the cyc_cnt/inst_cnt outputs.
// Ports:
//   cpu_clk, cpu_rstn    - clock, asynchronous active-low reset
//   inst_class           - decoder class, valid from ID onward
//   br_taken             - branch compare result, valid in EX
//   ifetch_ack, dmem_ack - instruction and data bus acknowledges
//   halt_req             - level request to stop at the next instruction boundary
//   ifetch_req, ir_we    - fetch request and instruction-register load
//   alu_bsel             - registered ALU B-port select
//   pc_we, npc_sel       - PC update strobe and next-PC source
//   rf_we, wd_sel        - register-file write and write-data source
//   dram_re, dram_we     - data read and write requests
//   halted, state        - halt indication and debug view of the current state
//   cyc_cnt, inst_cnt    - performance counters (MC_PERF_CNT_EN only)
//
// Bus handshake: a request (ifetch_req, dram_re, dram_we) stays high until
// the matching ack is sampled high on a rising edge while that request is
// asserted. The FSM completes the access in that same cycle. The FSM ignores
// an ack that arrives while no request is outstanding.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic [2:0]  inst_class,
  input  logic        br_taken,
  input  logic        ifetch_ack,
  input  logic        dmem_ack,
  input  logic        halt_req,
  output logic        ifetch_req,
  output logic        ir_we,
  output logic [1:0]  alu_bsel,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic        rf_we,
  output logic [1:0]  wd_sel,
  output logic        dram_re,
  output logic        dram_we,
  output logic        halted,
  output logic [2:0]  state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] inst_cnt
`endif
);

  logic [2:0] state_q, state_d, eoi_state;
  logic [2:0] cls_q;
  logic [1:0] bsel_q;
  logic       ifr, irw, pcw, rfw, re, we;
  logic [1:0] npc, wd;

  // The class and the B select are captured on the ID->EX edge. This keeps
  // both values stable for the rest of the instruction.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= S_IF;
      cls_q   <= CLS_ALU_R;
      bsel_q  <= ALUB_RS2;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        cls_q  <= inst_class;
        bsel_q <= bsel_of(inst_class);
      end
    end
  end

  // halt_req is only consulted here, at the end of an instruction.
  assign eoi_state = halt_req ? S_HALT : S_IF;

  always_comb begin
    state_d = state_q;
    ifr     = 1'b0;
    irw     = 1'b0;
    pcw     = 1'b0;
    npc     = NPC_SEQ;
    rfw     = 1'b0;
    wd      = WD_ALU;
    re      = 1'b0;
    we      = 1'b0;
    case (state_q)
      S_IF: begin
        ifr = 1'b1;
        if (ifetch_ack) begin
          irw     = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: state_d = S_EX;
      S_EX: begin
        case (cls_q)
          CLS_ALU_R, CLS_ALU_I, CLS_JUMP: state_d = S_WB;
          CLS_LOAD, CLS_STORE:            state_d = S_MEM;
          CLS_BRANCH: begin
            pcw     = 1'b1;
            npc     = br_taken ? NPC_BR : NPC_SEQ;
            state_d = eoi_state;
          end
          // Illegal classes retire as a NOP.
          default: begin
            pcw     = 1'b1;
            state_d = eoi_state;
          end
        endcase
      end
      S_MEM: begin
        re = (cls_q == CLS_LOAD);
        we = (cls_q != CLS_LOAD);
        if (dmem_ack) begin
          if (cls_q == CLS_LOAD) begin
            state_d = S_WB;
          end else begin
            pcw     = 1'b1;
            state_d = eoi_state;
          end
        end
      end
      S_WB: begin
        rfw     = 1'b1;
        pcw     = 1'b1;
        npc     = (cls_q == CLS_JUMP) ? NPC_JMP : NPC_SEQ;
        wd      = (cls_q == CLS_LOAD) ? WD_MEM :
                  (cls_q == CLS_JUMP) ? WD_PC4 : WD_ALU;
        state_d = eoi_state;
      end
      S_HALT: begin
        if (!halt_req) state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // The reset-state decode would otherwise raise ifetch_req during reset.
  // All combinational outputs are therefore forced low while cpu_rstn is low.
  assign ifetch_req = ifr & cpu_rstn;
  assign ir_we      = irw & cpu_rstn;
  assign pc_we      = pcw & cpu_rstn;
  assign npc_sel    = npc & {2{cpu_rstn}};
  assign rf_we      = rfw & cpu_rstn;
  assign wd_sel     = wd & {2{cpu_rstn}};
  assign dram_re    = re & cpu_rstn;
  assign dram_we    = we & cpu_rstn;
  assign alu_bsel   = bsel_q;
  assign halted     = (state_q == S_HALT);
  assign state      = state_q;

`ifdef MC_PERF_CNT_EN
  mc_perf_cnt u_perf (
    .clk      (cpu_clk),
    .rst_n    (cpu_rstn),
    .cnt_en   (state_q != S_HALT),
    .inst_inc (pc_we),
    .cyc_cnt  (cyc_cnt),
    .inst_cnt (inst_cnt)
  );
`endif

endmodule
